// File: rtl/cache_line_fill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cache_line_fill: serialises 256-bit cache lines into 32-bit BRAM accesses   |
// | (eviction writeback, then line fill with reassembly).  Rev 1.0             |
// +----------------------------------------------------------------------------+
module cache_line_fill #(
    parameter int LINE_ADDR_W = 9,
    parameter int WORDS       = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fill_req,
    input  logic [LINE_ADDR_W-1:0]   fill_line_addr,
    input  logic                     wb_req,
    input  logic [LINE_ADDR_W-1:0]   wb_line_addr,
    input  logic [255:0]             wb_line,
    output logic [255:0]             fill_line,
    output logic                     busy,
    output logic                     done,
    output logic [LINE_ADDR_W+2:0]   mem_addr,
    output logic                     mem_re,
    output logic                     mem_we,
    output logic [31:0]              mem_wdata,
    input  logic [31:0]              mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WB   = 3'd1,
        S_RD   = 3'd2,
        S_LAST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'(WORDS - 1);

    state_t                   state_q, state_d;
    logic [2:0]               cnt_q, cnt_d;
    logic                     fill_pend_q, fill_pend_d;
    logic [LINE_ADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [LINE_ADDR_W-1:0]   fill_addr_q, fill_addr_d;
    logic [255:0]             wb_line_q, wb_line_d;
    logic [255:0]             fill_line_q, fill_line_d;
    logic [2:0]               prev_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 3'd0;
            fill_pend_q <= 1'b0;
            wb_addr_q   <= '0;
            fill_addr_q <= '0;
            wb_line_q   <= '0;
            fill_line_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_pend_q <= fill_pend_d;
            wb_addr_q   <= wb_addr_d;
            fill_addr_q <= fill_addr_d;
            wb_line_q   <= wb_line_d;
            fill_line_q <= fill_line_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_pend_d = fill_pend_q;
        wb_addr_d   = wb_addr_q;
        fill_addr_d = fill_addr_q;
        wb_line_d   = wb_line_q;
        fill_line_d = fill_line_q;
        prev_idx    = cnt_q - 3'd1;
        busy        = 1'b1;
        done        = 1'b0;
        mem_addr    = '0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = 32'd0;

        case (state_q)
            S_IDLE: begin
                busy  = 1'b0;
                cnt_d = 3'd0;
                if (wb_req) begin
                    wb_addr_d   = wb_line_addr;
                    wb_line_d   = wb_line;
                    fill_addr_d = fill_line_addr;
                    fill_pend_d = fill_req;
                    state_d     = S_WB;
                end else if (fill_req) begin
                    fill_addr_d = fill_line_addr;
                    fill_pend_d = 1'b0;
                    state_d     = S_RD;
                end
            end
            S_WB: begin
                mem_we    = 1'b1;
                mem_addr  = {wb_addr_q, cnt_q};
                mem_wdata = wb_line_q[{cnt_q, 5'b0} +: 32];
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = 3'd0;
                    state_d = fill_pend_q ? S_RD : S_DONE;
                end
            end
            S_RD: begin
                mem_re   = 1'b1;
                mem_addr = {fill_addr_q, cnt_q};
                cnt_d    = cnt_q + 3'd1;
                // Read data lags the address by one cycle, so capture word cnt-1.
                if (cnt_q != 3'd0) begin
                    fill_line_d[{prev_idx, 5'b0} +: 32] = mem_rdata;
                end
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = 3'd0;
                    state_d = S_LAST;
                end
            end
            S_LAST: begin
                fill_line_d[{LAST_IDX, 5'b0} +: 32] = mem_rdata;
                state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fill_line = fill_line_q;

endmodule
`default_nettype wire

// File: tb/tb_cache_line_fill.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cache_line_fill: directed self-checking bench with a 1-cycle BRAM model. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_cache_line_fill;

    logic         clk;
    logic         rst_n;
    logic         fill_req;
    logic [8:0]   fill_line_addr;
    logic         wb_req;
    logic [8:0]   wb_line_addr;
    logic [255:0] wb_line;
    logic [255:0] fill_line;
    logic         busy;
    logic         done;
    logic [11:0]  mem_addr;
    logic         mem_re;
    logic         mem_we;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:4095];
    logic [11:0] re_addr [0:31];
    logic [11:0] we_addr [0:31];
    logic [31:0] we_data [0:31];
    int re_n, we_n, both_n, done_n;

    cache_line_fill #(.LINE_ADDR_W(9), .WORDS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fill_req       (fill_req),
        .fill_line_addr (fill_line_addr),
        .wb_req         (wb_req),
        .wb_line_addr   (wb_line_addr),
        .wb_line        (wb_line),
        .fill_line      (fill_line),
        .busy           (busy),
        .done           (done),
        .mem_addr       (mem_addr),
        .mem_re         (mem_re),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_re) begin
            if (re_n < 32) re_addr[re_n] = mem_addr;
            re_n++;
        end
        if (mem_we) begin
            if (we_n < 32) begin
                we_addr[we_n] = mem_addr;
                we_data[we_n] = mem_wdata;
            end
            we_n++;
        end
        if (mem_re && mem_we) both_n++;
        if (done) done_n++;
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mk(input logic [31:0] base);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = base + 32'(k);
        return v;
    endfunction

    // Issues a request at a negedge, measures cycles to done; optionally perturbs inputs mid-flight.
    task automatic run_txn(input logic wb, input logic fl, input logic [8:0] wa, input logic [8:0] fa,
                           input logic [255:0] wl, input bit perturb, output int lat);
        @(negedge clk);
        wb_req = wb; fill_req = fl; wb_line_addr = wa; fill_line_addr = fa; wb_line = wl;
        @(posedge clk);
        re_n = 0; we_n = 0; both_n = 0; done_n = 0;
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (perturb && lat == 3) begin
                wb_line_addr = 9'h0AA; fill_line_addr = 9'h155; wb_line = {8{32'hFFFF_FFFF}};
            end
            if (done) break;
        end
        wb_req = 1'b0; fill_req = 1'b0;
    endtask

    initial begin
        int lat;
        logic [255:0] exp_line;
        rst_n = 1'b0; fill_req = 1'b0; wb_req = 1'b0;
        fill_line_addr = '0; wb_line_addr = '0; wb_line = '0;
        re_n = 0; we_n = 0; both_n = 0; done_n = 0;
        for (int a = 0; a < 4096; a++) mem[a] = 32'd0;
        for (int k = 0; k < 8; k++) begin
            mem[12'h048 + 12'(k)] = 32'h1000_0000 + 32'(k);
            mem[12'h028 + 12'(k)] = 32'h5000_0000 + 32'(k);
        end

        #12;
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_re_we", 256'({mem_re, mem_we}), 256'd0);
        chk("rst_addr", 256'(mem_addr), 256'd0);
        chk("rst_wdata", 256'(mem_wdata), 256'd0);
        chk("rst_fill_line", fill_line, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill only, line 9 -> words 0x48..0x4F
        run_txn(1'b0, 1'b1, 9'd0, 9'd9, 256'd0, 1'b0, lat);
        chk("fill_latency", 256'(lat), 256'd10);
        chk("fill_line", fill_line, mk(32'h1000_0000));
        repeat (2) @(negedge clk);
        chk("fill_re_count", 256'(re_n), 256'd8);
        for (int k = 0; k < 8; k++) chk("fill_re_addr", 256'(re_addr[k]), 256'(12'h048 + 12'(k)));
        chk("fill_we_count", 256'(we_n), 256'd0);
        chk("fill_done_count", 256'(done_n), 256'd1);

        // Writeback line 3 then fill line 5; inputs perturbed mid-transaction
        run_txn(1'b1, 1'b1, 9'd3, 9'd5, mk(32'hA000_0000), 1'b1, lat);
        chk("wbf_latency", 256'(lat), 256'd18);
        chk("wbf_fill_line", fill_line, mk(32'h5000_0000));
        repeat (2) @(negedge clk);
        chk("wbf_we_count", 256'(we_n), 256'd8);
        chk("wbf_re_count", 256'(re_n), 256'd8);
        for (int k = 0; k < 8; k++) begin
            chk("wbf_we_addr", 256'(we_addr[k]), 256'(12'h018 + 12'(k)));
            chk("wbf_we_data", 256'(we_data[k]), 256'(32'hA000_0000 + 32'(k)));
            chk("wbf_re_addr", 256'(re_addr[k]), 256'(12'h028 + 12'(k)));
        end
        chk("wbf_done_count", 256'(done_n), 256'd1);
        chk("wbf_no_overlap", 256'(both_n), 256'd0);

        // Writeback only, line 0x1FF
        run_txn(1'b1, 1'b0, 9'h1FF, 9'd0, mk(32'hB000_0000), 1'b0, lat);
        chk("wb_latency", 256'(lat), 256'd9);
        repeat (2) @(negedge clk);
        chk("wb_we_count", 256'(we_n), 256'd8);
        chk("wb_we_addr0", 256'(we_addr[0]), 256'(12'hFF8));
        chk("wb_we_addr7", 256'(we_addr[7]), 256'(12'hFFF));
        chk("wb_we_data7", 256'(we_data[7]), 256'(32'hB000_0007));
        chk("wb_no_read", 256'(re_n), 256'd0);
        chk("wb_fill_line_kept", fill_line, mk(32'h5000_0000));
        chk("wb_done_count", 256'(done_n), 256'd1);

        // Same line for writeback and fill: read returns freshly written data
        run_txn(1'b1, 1'b1, 9'd2, 9'd2, mk(32'hDEAD_0000), 1'b0, lat);
        chk("same_latency", 256'(lat), 256'd18);
        chk("same_fill_line", fill_line, mk(32'hDEAD_0000));

        // Reset asserted during WB cycle 4
        @(negedge clk);
        wb_req = 1'b1; wb_line_addr = 9'd7; wb_line = mk(32'hC000_0000);
        @(posedge clk);
        re_n = 0; we_n = 0; both_n = 0; done_n = 0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 256'(busy), 256'd0);
        chk("arst_we", 256'(mem_we), 256'd0);
        chk("arst_addr", 256'(mem_addr), 256'd0);
        chk("arst_wdata", 256'(mem_wdata), 256'd0);
        chk("arst_fill_line", fill_line, 256'd0);
        wb_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("arst_we_count", 256'(we_n), 256'd4);
        chk("arst_no_done", 256'(done_n), 256'd0);

        // Fill after reset, fill_req held through done re-triggers one cycle later
        @(negedge clk);
        fill_req = 1'b1; fill_line_addr = 9'd9;
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (done) break;
        end
        chk("post_rst_latency", 256'(lat), 256'd10);
        exp_line = mk(32'h1000_0000);
        chk("post_rst_fill_line", fill_line, exp_line);
        @(negedge clk);
        chk("hold_idle_gap", 256'(busy), 256'd0);
        @(negedge clk);
        chk("hold_retrigger", 256'(busy), 256'd1);
        fill_req = 1'b0;
        lat = 1;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            @(negedge clk);
            lat++;
        end
        chk("retrigger_latency", 256'(lat), 256'd10);
        chk("retrigger_fill_line", fill_line, exp_line);
        repeat (3) @(negedge clk);
        chk("final_idle", 256'(busy), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Line transfer engine directly downstream of the data cache; moves whole 256-bit lines between the cache and a 32-bit-wide synchronous data BRAM.
- On a miss the cache requests a line fill and optionally an eviction writeback. The engine serialises each line into 8 word accesses, reassembles fetched words into a 256-bit line, then pulses done.
- Word k of a line occupies bits [32k+31:32k], matching the cache's byte-address bits [4:2] word offset.

Parameters:
- LINE_ADDR_W, 9, line address width (byte address bits [13:5]: 6 tag + 3 index).
- WORDS, 8, words per line; fixed at 8, not intended to be overridden.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fill_req  in  1  request to fetch line at fill_line_addr; held high by cache until done.
- fill_line_addr  in  LINE_ADDR_W  line address to fetch.
- wb_req  in  1  request to write wb_line to wb_line_addr before any fill; held until done.
- wb_line_addr  in  LINE_ADDR_W  line address of evicted line.
- wb_line  in  256  evicted line data.
- fill_line  out  256  assembled fetched line.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- mem_addr  out  LINE_ADDR_W+3  BRAM word address {line_addr, word_index}.
- mem_re  out  1  BRAM read enable; data returns on mem_rdata one cycle later.
- mem_we  out  1  BRAM write enable.
- mem_wdata  out  32  BRAM write data.
- mem_rdata  in  32  BRAM read data (1-cycle latency).

Behaviour:
- Reset (async, rst_n low): state IDLE, counter 0, fill_line 0, busy 0, done 0, mem_re 0, mem_we 0, mem_addr 0, mem_wdata 0. Reset mid-transfer aborts it immediately. No further mem_we is issued and no done is produced.
- Requests are sampled only in IDLE. Addresses and wb_line are latched at the sampling edge. Later input changes are ignored until the next IDLE.
- State machine (3-bit counter cnt):
  - IDLE: wb_req=1 -> WB; else fill_req=1 -> RD; else stay. cnt<=0 on exit.
  - WB: mem_we=1, mem_addr={wb_addr_l, cnt}, mem_wdata=wb_line_l word cnt. cnt increments. After cnt=7: fill_req latched -> RD (cnt<=0), else -> DONE.
  - RD: mem_re=1, mem_addr={fill_addr_l, cnt}. From the second RD cycle onward, mem_rdata is captured into fill_line word cnt-1. After cnt=7 -> LAST.
  - LAST: mem_re=0. Captures mem_rdata into word 7 -> DONE.
  - DONE: done=1 for exactly one cycle, busy=1 -> IDLE.
- mem_re and mem_we are never high in the same cycle. Both are 0 outside WB/RD.
- Latency from the sampling edge T: fill only, done in cycle T+10. Writeback + fill, done in T+18. Writeback only, done in T+9.
- fill_line holds its value from DONE until the next capture. It is valid only at and after done of a fill transaction. It is not modified by a writeback-only transaction.
- The counter wraps 7->0 only via the state transition. No partial-line transfers.
- Request that arrives in the same cycle done is high: not sampled. It is picked up in the following IDLE cycle, one cycle after done.
- Same address for writeback and fill: allowed. The read sees the just-written data because writes complete before the first read.

Test Plan:
- Reset, preload BRAM words 0x48..0x4F with 0x1000_0000+k; fill_req, fill_line_addr=9 -> mem_re high 8 cycles with addrs 0x48..0x4F; done in T+10; fill_line word k = 0x1000_0000+k.
- wb_req+fill_req, wb_line_addr=3, wb_line word k=0xA000_0000+k, fill_line_addr=5 -> writes to 0x18..0x1F with those values, then reads 0x28..0x2F; done at T+18, single pulse.
- wb_req only, addr=0x1FF -> writes to 0xFF8..0xFFF; done at T+9; fill_line unchanged; mem_re never asserted.
- wb_line_addr=fill_line_addr=2, wb data 0xDEAD_0000+k -> fill_line word k = 0xDEAD_0000+k.
- rst_n low during WB cycle 4 -> all outputs 0 asynchronously; no further mem_we; no done; a new fill after release completes normally.
- Change fill_line_addr and wb_line mid-transaction -> addresses and data used remain the latched values; fill_req held through done re-triggers only from IDLE one cycle after done.
